// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU-side arbiters (FPMUL now, FPADD/FPDIV later).
//   - state encoding for the issue/wait/respond sequencer
//   - bit positions inside the 6-bit flag word {OF,UF,NaNF,InfF,DNF,ZF}
//   - operand width and flag-word width
package fpu_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 6;

  // Flag bit positions, MSB first as the FPU units emit them.
  localparam int FLG_OF   = 5;
  localparam int FLG_UF   = 4;
  localparam int FLG_NANF = 3;
  localparam int FLG_INFF = 2;
  localparam int FLG_DNF  = 1;
  localparam int FLG_ZF   = 0;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   [NUM_REQ] : request levels
//   ptr   [ID_W]    : highest-priority index (must be < NUM_REQ)
//   valid           : some request is set
//   idx   [ID_W]    : first set request at or after ptr, wrapping around
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // slot[k] is the requester index that sits k places after ptr.
  logic [ID_W-1:0] slot [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic [ID_W:0] sum;
      assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
      // ptr < NUM_REQ, so one conditional subtract is a full modulo.
      assign slot[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                    : sum[ID_W-1:0];
    end
  endgenerate

  // Walk from the farthest slot to the nearest so the nearest set one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[slot[k]]) begin
        valid = 1'b1;
        idx   = slot[k];
      end
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter/sequencer sharing one FPMUL among NUM_REQ clients.
//   Clk, Rst             : clock, synchronous active-high reset
//   Req/Req_A/Req_B      : per-client request level and packed operand pairs (slot i = [32i+31:32i])
//   Gnt                  : one-hot pulse, operands of that client were taken
//   Rsp_Valid/Rsp_Id     : one-hot response pulse and index of the responding client
//   Rsp_P/Rsp_Flags      : captured product and flags (held until the next response)
//   Rsp_Err              : response produced by the watchdog, not by the multiplier
//   Busy                 : sequencer is not idle
//   Mul_A/Mul_B/Mul_Start: drive the shared FPMUL
//   Mul_P/Mul_Flags/Mul_Done : FPMUL result, Done is a one-cycle pulse
// Every output is a flop. One operation is in flight at a time; Start only pulses in ISSUE.
module fpmul_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_REQ-1:0]      Req,
  input  logic [NUM_REQ*32-1:0]   Req_A,
  input  logic [NUM_REQ*32-1:0]   Req_B,
  output logic [NUM_REQ-1:0]      Gnt,
  output logic [NUM_REQ-1:0]      Rsp_Valid,
  output logic [ID_W-1:0]         Rsp_Id,
  output logic [DATA_W-1:0]       Rsp_P,
  output logic [FLAG_W-1:0]       Rsp_Flags,
  output logic                    Rsp_Err,
  output logic                    Busy,
  output logic [DATA_W-1:0]       Mul_A,
  output logic [DATA_W-1:0]       Mul_B,
  output logic                    Mul_Start,
  input  logic [DATA_W-1:0]       Mul_P,
  input  logic [FLAG_W-1:0]       Mul_Flags,
  input  logic                    Mul_Done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Unpacked views of the operand buses.
  logic [DATA_W-1:0] req_a_arr [NUM_REQ];
  logic [DATA_W-1:0] req_b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = Req_A[32*gi +: 32];
      assign req_b_arr[gi] = Req_B[32*gi +: 32];
    end
  endgenerate

  // Sequencer state and datapath flops.
  state_t              state_q,     state_d;
  logic [ID_W-1:0]     ptr_q,       ptr_d;
  logic [ID_W-1:0]     id_q,        id_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [DATA_W-1:0]   mul_a_q,     mul_a_d;
  logic [DATA_W-1:0]   mul_b_q,     mul_b_d;
  logic                mul_start_q, mul_start_d;
  logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0]   rsp_p_q,     rsp_p_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q,   rsp_err_d;
  logic                busy_q,      busy_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;
  logic                timed_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (Req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, arbitration and operand latching.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          id_d    = pick_idx;
          ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          mul_a_d = req_a_arr[pick_idx];
          mul_b_d = req_b_arr[pick_idx];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Done has priority over the watchdog when both land together.
        if (Mul_Done || timed_out) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs, computed from the transition being taken.
  always_comb begin
    gnt_d       = '0;
    mul_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    rsp_flags_d = rsp_flags_q;
    busy_d      = (state_d != IDLE);

    if (state_q == IDLE && state_d == ISSUE) begin
      gnt_d[id_d] = 1'b1;
      mul_start_d = 1'b1;
    end

    if (state_q == WAIT && state_d == RESP) begin
      rsp_valid_d[id_q] = 1'b1;
      rsp_id_d          = id_q;
      if (Mul_Done) begin
        rsp_p_d     = Mul_P;
        rsp_flags_d = Mul_Flags;
      end else begin
        rsp_p_d     = '0;
        rsp_flags_d = '0;
        rsp_err_d   = 1'b1;
      end
    end
  end

  assign Gnt       = gnt_q;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Id    = rsp_id_q;
  assign Rsp_P     = rsp_p_q;
  assign Rsp_Flags = rsp_flags_q;
  assign Rsp_Err   = rsp_err_q;
  assign Busy      = busy_q;
  assign Mul_A     = mul_a_q;
  assign Mul_B     = mul_b_q;
  assign Mul_Start = mul_start_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb_fpmul_arbiter: self-checking bench for fpmul_arbiter with a behavioural 4-cycle FPMUL.
// Expected responses are queued when a request is driven and compared when Rsp_Valid pulses.
module tb_fpmul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  logic                  Clk;
  logic                  Rst;
  logic [NUM_REQ-1:0]    Req;
  logic [NUM_REQ*32-1:0] Req_A;
  logic [NUM_REQ*32-1:0] Req_B;
  logic [NUM_REQ-1:0]    Gnt;
  logic [NUM_REQ-1:0]    Rsp_Valid;
  logic [ID_W-1:0]       Rsp_Id;
  logic [31:0]           Rsp_P;
  logic [5:0]            Rsp_Flags;
  logic                  Rsp_Err;
  logic                  Busy;
  logic [31:0]           Mul_A;
  logic [31:0]           Mul_B;
  logic                  Mul_Start;
  logic [31:0]           Mul_P;
  logic [5:0]            Mul_Flags;
  logic                  Mul_Done;

  fpmul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .Req_A     (Req_A),
    .Req_B     (Req_B),
    .Gnt       (Gnt),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Id    (Rsp_Id),
    .Rsp_P     (Rsp_P),
    .Rsp_Flags (Rsp_Flags),
    .Rsp_Err   (Rsp_Err),
    .Busy      (Busy),
    .Mul_A     (Mul_A),
    .Mul_B     (Mul_B),
    .Mul_Start (Mul_Start),
    .Mul_P     (Mul_P),
    .Mul_Flags (Mul_Flags),
    .Mul_Done  (Mul_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // Behavioural FPMUL for normal operands: truncating single-precision multiply.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] m;
    int          e;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 1;
    end else begin
      f = m[45:23];
    end
    return {s, e[7:0], f};
  endfunction

  logic       model_hang  = 1'b0;
  logic [5:0] model_flags = 6'd0;
  logic       model_done  = 1'b0;
  logic       stray_done  = 1'b0;
  logic [31:0] model_p    = 32'd0;
  int          mcnt       = 0;

  // Done is high in the 4th cycle after the Start cycle.
  always @(posedge Clk) begin
    if (Rst) begin
      mcnt       <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (Mul_Start) begin
        mcnt    <= model_hang ? 0 : 3;
        model_p <= fmul(Mul_A, Mul_B);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) model_done <= 1'b1;
      end
    end
  end

  assign Mul_P     = model_p;
  assign Mul_Flags = model_flags;
  assign Mul_Done  = model_done | stray_done;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     p;
    logic [5:0]      flags;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cnt   = 0;
  int   rsp_cyc   = 0;
  int   start_cnt = 0;

  // Response monitor / scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (Mul_Start) start_cnt++;
    if (Rsp_Valid != '0) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(Rsp_Valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_valid", 32'(Rsp_Valid), 32'(4'b0001 << e.id));
        check("rsp_id",    32'(Rsp_Id),    32'(e.id));
        check("rsp_p",     Rsp_P,          e.p);
        check("rsp_flags", 32'(Rsp_Flags), 32'(e.flags));
        check("rsp_err",   32'(Rsp_Err),   32'(e.err));
        $display("rsp id=%0d p=0x%08h flags=%06b err=%0d @%0d", Rsp_Id, Rsp_P, Rsp_Flags, Rsp_Err, cyc);
      end
    end
  end

  task automatic push_exp(input int id, input logic err);
    exp_t e;
    e.id    = ID_W'(id);
    e.err   = err;
    e.p     = err ? 32'd0 : fmul(Req_A[32*id +: 32], Req_B[32*id +: 32]);
    e.flags = err ? 6'd0 : model_flags;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(output int cg, output logic [NUM_REQ-1:0] g);
    cg = -1;
    g  = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Gnt != '0) begin
        cg = cyc;
        g  = Gnt;
        break;
      end
    end
    if (cg < 0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge Clk);
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  // One request from mask, expecting requester exp_id to win; returns drive and grant cycles.
  task automatic single_op(input logic [NUM_REQ-1:0] mask, input int exp_id, input logic err,
                           output int c0, output int cg);
    logic [NUM_REQ-1:0] g;
    push_exp(exp_id, err);
    Req = mask;
    c0  = cyc;
    wait_gnt(cg, g);
    check("gnt_onehot", 32'(g), 32'(4'b0001 << exp_id));
    $display("gnt req=%04b -> %04b @%0d", mask, g, cg);
    Req = '0;
    wait_drain();
  endtask

  initial begin
    int c0, cg, prev, s0, r0;
    logic [NUM_REQ-1:0] g;

    Rst   = 1'b1;
    Req   = '0;
    Req_A = {32'h3F400000, 32'h40400000, 32'h3FC00000, 32'h3F800000};
    Req_B = {32'h40800000, 32'h3FC00000, 32'h40400000, 32'h40000000};
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // Reset state.
    check("rst_gnt",   32'(Gnt),       32'd0);
    check("rst_rspv",  32'(Rsp_Valid), 32'd0);
    check("rst_busy",  32'(Busy),      32'd0);
    check("rst_start", 32'(Mul_Start), 32'd0);
    check("rst_mula",  Mul_A,          32'd0);
    check("rst_rspp",  Rsp_P,          32'd0);
    check("rst_err",   32'(Rsp_Err),   32'd0);

    // Single request: 1.0 * 2.0, with latency and Start-pulse checks.
    @(negedge Clk);
    exp_q.push_back('{id: 2'd0, p: 32'h40000000, flags: 6'd0, err: 1'b0});
    s0  = start_cnt;
    Req = 4'b0001;
    c0  = cyc;
    wait_gnt(cg, g);
    check("t1_gnt",       32'(g),         32'h1);
    check("t1_gnt_cyc",   32'(cg - c0),   32'd1);
    check("t1_start",     32'(Mul_Start), 32'd1);
    check("t1_mula",      Mul_A,          32'h3F800000);
    check("t1_busy",      32'(Busy),      32'd1);
    Req = '0;
    wait_drain();
    check("t1_rsp_cyc",   32'(rsp_cyc - c0),      32'd6);
    check("t1_start_cnt", 32'(start_cnt - s0),    32'd1);

    // Contention from pointer 0: order 0,1,2,3,0, 7 cycles apart.
    do_reset();
    @(negedge Clk);
    for (int k = 0; k < 5; k++) push_exp(k % 4, 1'b0);
    Req  = 4'b1111;
    c0   = cyc;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(cg, g);
      $display("gnt req=1111 -> %04b @%0d", g, cg);
      check($sformatf("cont_gnt%0d", k), 32'(g), 32'(4'b0001 << (k % 4)));
      if (k == 0) check("cont_first_cyc", 32'(cg - c0), 32'd1);
      else        check("cont_spacing",   32'(cg - prev), 32'd7);
      prev = cg;
    end
    Req = '0;
    wait_drain();

    // Pointer wrap (pointer is 1 here).
    single_op(4'b0100, 2, 1'b0, c0, cg);
    single_op(4'b0101, 0, 1'b0, c0, cg);
    single_op(4'b0100, 2, 1'b0, c0, cg);
    single_op(4'b1001, 3, 1'b0, c0, cg);

    // Watchdog: no Done, then a normal operation.
    model_hang = 1'b1;
    single_op(4'b0001, 0, 1'b1, c0, cg);
    check("to_rsp_cyc", 32'(rsp_cyc - c0), 32'(TIMEOUT + 3));
    model_hang = 1'b0;
    single_op(4'b0010, 1, 1'b0, c0, cg);
    check("to_after_err", 32'(Rsp_Err), 32'd0);

    // Flag passthrough, then a stray Done while idle.
    model_flags = 6'b100001;
    single_op(4'b0100, 2, 1'b0, c0, cg);
    model_flags = 6'd0;
    @(negedge Clk);
    r0 = rsp_cnt;
    stray_done = 1'b1;
    @(negedge Clk);
    stray_done = 1'b0;
    repeat (4) @(negedge Clk);
    check("stray_busy", 32'(Busy),         32'd0);
    check("stray_rsp",  32'(rsp_cnt - r0), 32'd0);

    // Reset in WAIT: operation dropped, pointer back to 0.
    Req = 4'b0010;
    wait_gnt(cg, g);
    check("mr_gnt", 32'(g), 32'h2);
    Req = '0;
    r0 = rsp_cnt;
    repeat (3) @(negedge Clk);
    check("mr_busy_before", 32'(Busy), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("mr_busy_after", 32'(Busy), 32'd0);
    repeat (10) @(negedge Clk);
    check("mr_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    single_op(4'b1001, 0, 1'b0, c0, cg);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one FPMUL unit among NUM_REQ requesters.
- Takes each requester's operand pair and drives the unit's Start/A/B. It then waits for Done and captures the product and flags. The result returns to the originating requester with a one-cycle valid pulse.
- A watchdog aborts a hung operation.
- Sits between the FPU client ports and the single FPMUL instance. It is the only driver of that unit's Start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).
- TIMEOUT, 16, maximum WAIT cycles before abort (≥ 5).

Ports:
- Clk  in  1  clock; every register updates on the rising edge.
- Rst  in  1  reset, synchronous and active-high.
- Req  in  NUM_REQ  per-requester request level.
- Req_A  in  NUM_REQ*32  operand 1; slot i is bits [32i+31:32i].
- Req_B  in  NUM_REQ*32  operand 2; same packing as Req_A.
- Gnt  out  NUM_REQ  one-hot, one-cycle pulse: operands accepted.
- Rsp_Valid  out  NUM_REQ  one-hot, one-cycle pulse: response valid.
- Rsp_Id  out  ID_W  index of the responding requester.
- Rsp_P  out  32  captured product.
- Rsp_Flags  out  6  captured {OF,UF,NaNF,InfF,DNF,ZF}.
- Rsp_Err  out  1  set with Rsp_Valid when the watchdog expired.
- Busy  out  1  high in any state other than IDLE.
- Mul_A  out  32  operand 1 to FPMUL.
- Mul_B  out  32  operand 2 to FPMUL.
- Mul_Start  out  1  FPMUL Start.
- Mul_P  in  32  FPMUL product.
- Mul_Flags  in  6  FPMUL flags, same order as Rsp_Flags.
- Mul_Done  in  1  FPMUL Done, a one-cycle pulse.

Behaviour:
- All outputs are registered.
- Reset: state goes to IDLE and the RR pointer to 0. Gnt, Rsp_Valid, Rsp_Id, Rsp_P, Rsp_Flags, Rsp_Err, Busy, Mul_A, Mul_B and Mul_Start all go to 0.
- Reset mid-operation abandons the operation and produces no response. FPMUL shares Rst, so it is also cleared.
- IDLE:
  - If Req is nonzero, select the first set bit at or after the RR pointer, wrapping around.
  - Latch that requester's A and B into Mul_A/Mul_B, latch the index, then go to ISSUE.
  - Set the RR pointer to index+1 mod NUM_REQ.
  - If Req is zero, stay in IDLE.
- ISSUE (1 cycle): Mul_Start=1 and Gnt[id]=1. Then go to WAIT with the watchdog counter cleared.
- WAIT:
  - Mul_Start=0 and Mul_A/Mul_B are held.
  - Mul_Done=1: capture Mul_P and Mul_Flags, set err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: set captured P=0, flags=0, err=1, go to RESP.
  - Mul_Done wins if both occur in the same cycle.
  - Mul_Done seen in IDLE, ISSUE or RESP is ignored.
- RESP (1 cycle): Rsp_Valid[id]=1 with Rsp_Id, Rsp_P, Rsp_Flags and Rsp_Err. Then go to IDLE.
- Rsp_P, Rsp_Flags and Rsp_Id hold their values until the next RESP. Rsp_Err clears on leaving RESP.
- Latency with a 4-cycle FPMUL:
  - Req seen in IDLE at cycle 0.
  - Gnt and Start at cycle 1.
  - Done at cycle 5.
  - Rsp_Valid at cycle 6.
  - Next arbitration at cycle 7; sustained throughput is one operation per 7 cycles.
- Requester rules:
  - Hold Req, Req_A and Req_B stable until Gnt is seen.
  - Req still high after Gnt is treated as a new request at the next IDLE.
  - Dropping Req before Gnt withdraws the request. It is legal only while that requester is not selected; once selected in IDLE, the latched operands are used regardless.
- Only one operation is ever in flight. Mul_Start is never asserted outside ISSUE, so FPMUL is never restarted mid-count.
- Fairness: under a continuous all-ones Req, every requester is granted once per NUM_REQ operations.

Decomposition:
- Shared package fpu_pkg holds:
  - state encoding localparams: IDLE, ISSUE, WAIT, RESP;
  - the flag-bit index constants: FLG_OF … FLG_ZF;
  - the FLAG_W=6 constant.
- One sub-module, rr_pick. It is combinational: inputs req[NUM_REQ] and ptr[ID_W]; outputs valid and idx[ID_W]. It is reused by future FPADD/FPDIV arbiters.

Test Plan:
- Reset, single request:
  - Stimulus: Req=0001, Req_A=0x3F800000, Req_B=0x40000000, behavioural FPMUL model.
  - Response: Gnt=0001 at cycle 1, Mul_Start a single pulse, Rsp_Valid=0001 at cycle 6, Rsp_Id=0, Rsp_P=0x40000000, Rsp_Err=0.
- Contention:
  - Stimulus: Req=1111 held with pointer=0.
  - Response: grant order 0,1,2,3,0; consecutive Gnt pulses exactly 7 cycles apart.
- Pointer wrap:
  - Stimulus: after a grant to requester 2, Req=0101.
  - Response: next grant goes to requester 0. With Req=1001 instead, the next grant goes to requester 3.
- Timeout:
  - Stimulus: model never asserts Mul_Done.
  - Response: Rsp_Valid at cycle 1+1+TIMEOUT+1 after the Req cycle, Rsp_Err=1, Rsp_P=0, Rsp_Flags=0; the next request is served normally.
- Reset mid-operation:
  - Stimulus: assert Rst for 1 cycle during WAIT.
  - Response: no Rsp_Valid for that operation, Busy=0 the cycle after reset, RR pointer=0.
- Flag passthrough and stray Done:
  - Stimulus: model returns Mul_Flags=6'b100001. Also inject a Mul_Done pulse while in IDLE.
  - Response: Rsp_Flags=6'b100001. The stray Done causes no state change and no Rsp_Valid.
